// File: rtl/uart_pkg.sv
// uart_pkg: constants and helpers shared by the UART transmitter and receiver.
//
// Contents:
//   BAUD_*        - supported line rates in bits per second
//   BPS_DR_W      - width of the per-bit divisor counter
//   uart_state_e  - frame state encoding (idle, start bit, data bits, stop bit)
//   bps_dr_calc() - divisor terminal count for one baud rate at a given clock period
//   bps_dr()      - rate-select code to divisor terminal count lookup
package uart_pkg;

    localparam int unsigned BAUD_9600   = 9600;
    localparam int unsigned BAUD_19200  = 19200;
    localparam int unsigned BAUD_38400  = 38400;
    localparam int unsigned BAUD_57600  = 57600;
    localparam int unsigned BAUD_115200 = 115200;

    localparam int unsigned NS_PER_S = 1000000000;

    // Wide enough for the slowest rate (9600) at a 20 ns clock: 5207.
    localparam int unsigned BPS_DR_W = 13;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } uart_state_e;

    // Terminal count of the divisor: one bit lasts (result + 1) clock cycles.
    // Integer division truncates at each step, matching the established rate table.
    function automatic logic [BPS_DR_W-1:0] bps_dr_calc(input int unsigned baud,
                                                        input int unsigned clk_period_ns);
        int unsigned cycles;
        cycles = NS_PER_S / baud / clk_period_ns;
        return BPS_DR_W'(cycles - 1);
    endfunction

    // Rate select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, anything else 9600.
    // Every arm depends only on constants, so this reduces to a mux of constants.
    function automatic logic [BPS_DR_W-1:0] bps_dr(input logic [2:0]  baud_set,
                                                   input int unsigned clk_period_ns);
        logic [BPS_DR_W-1:0] dr;
        case (baud_set)
            3'd1:    dr = bps_dr_calc(BAUD_19200, clk_period_ns);
            3'd2:    dr = bps_dr_calc(BAUD_38400, clk_period_ns);
            3'd3:    dr = bps_dr_calc(BAUD_57600, clk_period_ns);
            3'd4:    dr = bps_dr_calc(BAUD_115200, clk_period_ns);
            default: dr = bps_dr_calc(BAUD_9600, clk_period_ns);
        endcase
        return dr;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 UART byte transmitter.
//
// A request (Send_en high while idle) latches Data and Baud_set; the frame
// (start bit, Data[0..7] LSB first, stop bit) is then shifted out with each bit
// lasting bps_dr(Baud_set)+1 clock cycles. All outputs are registered.
//
// Ports:
//   Clk       in   system clock, rising edge
//   Reset     in   synchronous active-high reset; aborts any frame in flight
//   Baud_set  in   [2:0] rate select, sampled on acceptance
//   Data      in   [7:0] byte to send, sampled on acceptance
//   Send_en   in   transmit request, level sensitive, ignored while busy
//   uart_tx   out  serial line, idle high
//   Tx_Busy   out  high for every cycle of the frame (start through stop)
//   Tx_Done   out  one-cycle pulse on the first idle cycle after the stop bit
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PERIOD_NS = 20
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [2:0] Baud_set,
    input  logic [7:0] Data,
    input  logic       Send_en,
    output logic       uart_tx,
    output logic       Tx_Busy,
    output logic       Tx_Done
);

    uart_state_e         state_q;
    logic [BPS_DR_W-1:0] div_cnt_q;
    logic [2:0]          bit_idx_q;
    logic [7:0]          data_q;
    logic [2:0]          baud_q;
    logic                tx_q;
    logic                busy_q;
    logic                done_q;

    logic [BPS_DR_W-1:0] bps_dr_sel;
    logic                bit_end;
    logic [2:0]          bit_idx_nxt;

    // Divisor is taken from the latched rate so mid-frame Baud_set changes are inert.
    always_comb begin
        bps_dr_sel  = bps_dr(baud_q, CLK_PERIOD_NS);
        bit_end     = (div_cnt_q == bps_dr_sel);
        bit_idx_nxt = bit_idx_q + 3'd1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= StIdle;
            div_cnt_q <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            baud_q    <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Divisor runs only inside a frame and restarts on every bit boundary.
            if (state_q == StIdle || bit_end) begin
                div_cnt_q <= '0;
            end else begin
                div_cnt_q <= div_cnt_q + 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    bit_idx_q <= '0;
                    tx_q      <= 1'b1;
                    busy_q    <= 1'b0;
                    // Also taken on the Tx_Done cycle, giving back-to-back frames.
                    if (Send_en) begin
                        state_q <= StStart;
                        data_q  <= Data;
                        baud_q  <= Baud_set;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end

                StStart: begin
                    if (bit_end) begin
                        state_q   <= StData;
                        bit_idx_q <= '0;
                        tx_q      <= data_q[0];
                    end
                end

                StData: begin
                    if (bit_end) begin
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_nxt;
                            tx_q      <= data_q[bit_idx_nxt];
                        end
                    end
                end

                StStop: begin
                    if (bit_end) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign uart_tx = tx_q;
    assign Tx_Busy = busy_q;
    assign Tx_Done = done_q;

endmodule
